// File: rtl/sw_mode_ctrl_if.sv
// Stopwatch mode-controller bus: debounced buttons and counter flags in,
// mode state and counter controls out.
interface sw_mode_ctrl_if;
    logic       btn_start;
    logic       btn_mode;
    logic       btn_clear;
    logic       cnt_zero;
    logic       cnt_max;
    logic [1:0] current_state;
    logic       cnt_en;
    logic       cnt_dir;
    logic       cnt_clr;
    logic       alarm;

    modport master (
        output btn_start, btn_mode, btn_clear, cnt_zero, cnt_max,
        input  current_state, cnt_en, cnt_dir, cnt_clr, alarm
    );

    modport slave (
        input  btn_start, btn_mode, btn_clear, cnt_zero, cnt_max,
        output current_state, cnt_en, cnt_dir, cnt_clr, alarm
    );
endinterface

// File: rtl/sw_mode_ctrl.sv
// Stopwatch mode controller: up/down wait/run FSM driving the BCD counter.
// Optional timed alarm on down-count expiry is built when SW_ALARM_EN is defined.
module sw_mode_ctrl #(
    parameter int unsigned ALARM_CYCLES = 50000000
) (
    input  logic         clk,
    input  logic         rst_n,
    sw_mode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        UP_WAIT   = 2'b00,
        UP_RUN    = 2'b01,
        DOWN_WAIT = 2'b10,
        DOWN_RUN  = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic   prev_start, prev_mode, prev_clear;
    logic   press_start, press_mode, press_clear, press_any;
    logic   clr_d, cnt_clr_q;
    logic   expiry_dn;

    assign press_start = bus.btn_start & ~prev_start;
    assign press_mode  = bus.btn_mode  & ~prev_mode;
    assign press_clear = bus.btn_clear & ~prev_clear;
    assign press_any   = press_start | press_mode | press_clear;

    // History resets high so a button held through reset release is not a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= UP_WAIT;
            cnt_clr_q  <= 1'b0;
            prev_start <= 1'b1;
            prev_mode  <= 1'b1;
            prev_clear <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_clr_q  <= clr_d;
            prev_start <= bus.btn_start;
            prev_mode  <= bus.btn_mode;
            prev_clear <= bus.btn_clear;
        end
    end

    // Only the highest-priority press acts: clear, then mode, then start.
    always_comb begin
        state_d   = state_q;
        clr_d     = 1'b0;
        expiry_dn = 1'b0;
        if (press_clear) begin
            clr_d = 1'b1;
            case (state_q)
                UP_RUN:   state_d = UP_WAIT;
                DOWN_RUN: state_d = DOWN_WAIT;
                default:  state_d = state_q;
            endcase
        end else if (press_mode) begin
            case (state_q)
                UP_WAIT:   state_d = DOWN_WAIT;
                DOWN_WAIT: state_d = UP_WAIT;
                default:   state_d = state_q;
            endcase
        end else if (press_start) begin
            case (state_q)
                UP_WAIT:   state_d = bus.cnt_max  ? UP_WAIT   : UP_RUN;
                UP_RUN:    state_d = UP_WAIT;
                DOWN_WAIT: state_d = bus.cnt_zero ? DOWN_WAIT : DOWN_RUN;
                DOWN_RUN:  state_d = DOWN_WAIT;
                default:   state_d = UP_WAIT;
            endcase
        end else begin
            if (state_q == UP_RUN && bus.cnt_max) begin
                state_d = UP_WAIT;
            end else if (state_q == DOWN_RUN && bus.cnt_zero) begin
                state_d   = DOWN_WAIT;
                expiry_dn = 1'b1;
            end
        end
    end

    // Enable drops in the same cycle the limit flag rises so the counter never wraps.
    assign bus.cnt_en = ((state_q == UP_RUN)   && !bus.cnt_max) ||
                        ((state_q == DOWN_RUN) && !bus.cnt_zero);
    assign bus.current_state = state_q;
    assign bus.cnt_dir       = ~state_q[1];
    assign bus.cnt_clr       = cnt_clr_q;

`ifdef SW_ALARM_EN
    logic        alarm_q;
    logic [31:0] alarm_cnt;

    // Counter holds the remaining high cycles; any press cancels immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_q   <= 1'b0;
            alarm_cnt <= 32'd0;
        end else if (press_any) begin
            alarm_q   <= 1'b0;
            alarm_cnt <= 32'd0;
        end else if (expiry_dn) begin
            alarm_q   <= 1'b1;
            alarm_cnt <= ALARM_CYCLES;
        end else if (alarm_q) begin
            alarm_cnt <= alarm_cnt - 32'd1;
            if (alarm_cnt == 32'd1) begin
                alarm_q <= 1'b0;
            end
        end
    end

    assign bus.alarm = alarm_q;
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = expiry_dn | press_any | (ALARM_CYCLES == 0);
    assign bus.alarm = 1'b0;
`endif

endmodule

// File: tb/tb_sw_mode_ctrl.sv
// Directed bench for sw_mode_ctrl; alarm timing checks are compiled in when
// SW_ALARM_EN is defined, otherwise alarm is checked to stay low.
module tb_sw_mode_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    sw_mode_ctrl_if bus ();

    sw_mode_ctrl #(.ALARM_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 start, 1 mode, 2 clear; one-cycle press then release
    task automatic press_btn(input int which);
        case (which)
            0: bus.btn_start = 1'b1;
            1: bus.btn_mode  = 1'b1;
            default: bus.btn_clear = 1'b1;
        endcase
        tick();
        bus.btn_start = 1'b0;
        bus.btn_mode  = 1'b0;
        bus.btn_clear = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.btn_start = 1'b1; bus.btn_mode = 1'b0; bus.btn_clear = 1'b0;
        bus.cnt_zero = 1'b0; bus.cnt_max = 1'b0;
        tick(); tick();
        vectors++; if (bus.current_state !== 2'b00) begin miscompares++; $display("FAIL reset_state: got %b want 00", bus.current_state); end
        vectors++; if ({bus.cnt_en, bus.cnt_dir, bus.cnt_clr, bus.alarm} !== 4'b0100) begin miscompares++; $display("FAIL reset_outs: en/dir/clr/alarm got %b want 0100", {bus.cnt_en, bus.cnt_dir, bus.cnt_clr, bus.alarm}); end
        rst_n = 1'b1;
        tick(); tick();
        vectors++; if (bus.current_state !== 2'b00) begin miscompares++; $display("FAIL held_through_reset: got %b want 00", bus.current_state); end
        bus.btn_start = 1'b0;
        tick();
        bus.btn_start = 1'b1;
        tick();
        vectors++; if (bus.current_state !== 2'b01) begin miscompares++; $display("FAIL start_latency: got %b want 01", bus.current_state); end
        vectors++; if ({bus.cnt_en, bus.cnt_dir} !== 2'b11) begin miscompares++; $display("FAIL up_run_ctrl: en/dir got %b want 11", {bus.cnt_en, bus.cnt_dir}); end
        bus.btn_start = 1'b0;
        tick();
        press_btn(0);
        vectors++; if (bus.current_state !== 2'b00) begin miscompares++; $display("FAIL stop_up: got %b want 00", bus.current_state); end
    endtask

    task automatic test_mode();
        bus.btn_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.current_state !== 2'b10) begin miscompares++; $display("FAIL mode_hold[%0d]: got %b want 10", i, bus.current_state); end
        end
        bus.btn_mode = 1'b0;
        tick();
        vectors++; if (bus.cnt_dir !== 1'b0) begin miscompares++; $display("FAIL down_dir: got %b want 0", bus.cnt_dir); end
        press_btn(0);
        vectors++; if (bus.current_state !== 2'b11) begin miscompares++; $display("FAIL start_down: got %b want 11", bus.current_state); end
        press_btn(1);
        vectors++; if (bus.current_state !== 2'b11) begin miscompares++; $display("FAIL mode_in_run: got %b want 11", bus.current_state); end
        press_btn(0);
        vectors++; if (bus.current_state !== 2'b10) begin miscompares++; $display("FAIL stop_down: got %b want 10", bus.current_state); end
        bus.cnt_zero = 1'b1;
        press_btn(0);
        vectors++; if (bus.current_state !== 2'b10) begin miscompares++; $display("FAIL start_at_zero: got %b want 10", bus.current_state); end
        bus.cnt_zero = 1'b0;
        tick();
    endtask

    task automatic test_down_expiry();
        press_btn(0);
        vectors++; if ({bus.current_state, bus.cnt_en} !== 3'b111) begin miscompares++; $display("FAIL down_run_en: state/en got %b want 111", {bus.current_state, bus.cnt_en}); end
        bus.cnt_zero = 1'b1;
        #1;
        vectors++; if ({bus.current_state, bus.cnt_en} !== 3'b110) begin miscompares++; $display("FAIL zero_en_drop: state/en got %b want 110", {bus.current_state, bus.cnt_en}); end
        tick();
        vectors++; if (bus.current_state !== 2'b10) begin miscompares++; $display("FAIL down_expiry: got %b want 10", bus.current_state); end
`ifdef SW_ALARM_EN
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.alarm !== 1'b1) begin miscompares++; $display("FAIL alarm_high[%0d]: got %b want 1", i, bus.alarm); end
            tick();
        end
        vectors++; if (bus.alarm !== 1'b0) begin miscompares++; $display("FAIL alarm_end: got %b want 0", bus.alarm); end
`else
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.alarm !== 1'b0) begin miscompares++; $display("FAIL alarm_off[%0d]: got %b want 0", i, bus.alarm); end
            tick();
        end
`endif
        bus.cnt_zero = 1'b0;
        tick();
    endtask

    task automatic test_up_expiry();
        press_btn(1);
        press_btn(0);
        vectors++; if (bus.current_state !== 2'b01) begin miscompares++; $display("FAIL to_up_run: got %b want 01", bus.current_state); end
        bus.cnt_max = 1'b1;
        #1;
        vectors++; if (bus.cnt_en !== 1'b0) begin miscompares++; $display("FAIL max_en_drop: got %b want 0", bus.cnt_en); end
        tick();
        vectors++; if ({bus.current_state, bus.alarm} !== 3'b000) begin miscompares++; $display("FAIL up_expiry: state/alarm got %b want 000", {bus.current_state, bus.alarm}); end
        tick();
        vectors++; if (bus.alarm !== 1'b0) begin miscompares++; $display("FAIL up_no_alarm: got %b want 0", bus.alarm); end
        press_btn(0);
        vectors++; if (bus.current_state !== 2'b00) begin miscompares++; $display("FAIL start_at_max: got %b want 00", bus.current_state); end
        bus.cnt_max = 1'b0;
        tick();
    endtask

    task automatic test_clear_priority();
        press_btn(0);
        bus.btn_start = 1'b1; bus.btn_mode = 1'b1; bus.btn_clear = 1'b1;
        tick();
        vectors++; if ({bus.current_state, bus.cnt_clr} !== 3'b001) begin miscompares++; $display("FAIL clr_priority: state/clr got %b want 001", {bus.current_state, bus.cnt_clr}); end
        bus.btn_start = 1'b0; bus.btn_mode = 1'b0; bus.btn_clear = 1'b0;
        tick();
        vectors++; if ({bus.current_state, bus.cnt_clr} !== 3'b000) begin miscompares++; $display("FAIL clr_pulse_end: state/clr got %b want 000", {bus.current_state, bus.cnt_clr}); end
    endtask

    task automatic test_alarm_cancel();
        press_btn(1);
        press_btn(0);
        bus.cnt_zero = 1'b1;
        tick();
        vectors++; if (bus.current_state !== 2'b10) begin miscompares++; $display("FAIL cancel_setup: got %b want 10", bus.current_state); end
        tick();
`ifdef SW_ALARM_EN
        vectors++; if (bus.alarm !== 1'b1) begin miscompares++; $display("FAIL alarm_cycle2: got %b want 1", bus.alarm); end
`endif
        bus.btn_clear = 1'b1;
        tick();
        vectors++; if ({bus.current_state, bus.cnt_clr, bus.alarm} !== 4'b1010) begin miscompares++; $display("FAIL clear_cancel: state/clr/alarm got %b want 1010", {bus.current_state, bus.cnt_clr, bus.alarm}); end
        bus.btn_clear = 1'b0;
        tick();
        vectors++; if ({bus.cnt_clr, bus.alarm} !== 2'b00) begin miscompares++; $display("FAIL after_cancel: clr/alarm got %b want 00", {bus.cnt_clr, bus.alarm}); end
        bus.cnt_zero = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        press_btn(0);
        vectors++; if (bus.current_state !== 2'b11) begin miscompares++; $display("FAIL mid_setup: got %b want 11", bus.current_state); end
        rst_n = 1'b0;
        bus.btn_start = 1'b1;
        tick();
        vectors++; if ({bus.current_state, bus.cnt_en, bus.cnt_clr, bus.alarm} !== 5'b00000) begin miscompares++; $display("FAIL mid_reset: state/en/clr/alarm got %b want 00000", {bus.current_state, bus.cnt_en, bus.cnt_clr, bus.alarm}); end
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.current_state !== 2'b00) begin miscompares++; $display("FAIL no_pending_press: got %b want 00", bus.current_state); end
        bus.btn_start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_mode();
        test_down_expiry();
        test_up_expiry();
        test_clear_priority();
        test_alarm_cancel();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
